int2fp_stream: RTL and testbench

INT2FP_STREAM -- requirements
Module: int2fp_stream

---
 rtl/fp_pkg.sv | 12 +
 rtl/int2fp_stream_if.sv | 10 +
 rtl/lzc32.sv | 13 +
 rtl/int2fp_stream.sv | 70 +++++++
 tb/tb_int2fp_stream.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/fp_pkg.sv
// fp_pkg: shared IEEE-754 single-precision constants and field layout.
package fp_pkg;
   localparam int EXP_BIAS = 127;
   localparam int MANT_W = 23;
   localparam int EXP_W = 8;
   localparam logic [31:0] FP_ZERO = 32'h0000_0000;
   typedef struct packed {
      logic sign;
      logic [EXP_W-1:0] exp;
      logic [MANT_W-1:0] mant;
   } fp32_t;
endpackage

// File: rtl/int2fp_stream_if.sv
// int2fp_stream_if: AXI-Stream word channel with producer/consumer modports.
interface int2fp_stream_if #(parameter int DATA_WIDTH = 32);
   logic tvalid;
   logic tready;
   logic tlast;
   logic [DATA_WIDTH-1:0] tdata;
   logic [DATA_WIDTH/8-1:0] tstrb;
   modport master (output tvalid, tdata, tstrb, tlast, input tready);
   modport slave (input tvalid, tdata, tlast, output tready);
endinterface

// File: rtl/lzc32.sv
// lzc32: leading-zero count of a 32-bit word, with all-zero flag.
module lzc32 (
   input  logic [31:0] din,
   output logic [5:0]  cnt,
   output logic        zero
);
   always_comb begin
      cnt = 6'd32;
      for (int i = 0; i < 32; i++)
         if (din[i]) cnt = 6'(31 - i);
   end
   assign zero = ~|din;
endmodule

// File: rtl/int2fp_stream.sv
// int2fp_stream: 3-stage int32 -> fp32 stream converter with frame tlast and frame check.
module int2fp_stream
   import fp_pkg::*;
#(
   parameter int SIZE = 10,
   parameter int DATA_WIDTH = 32
) (
   input  logic             s00_axi_aclk,
   input  logic             s00_axi_aresetn,
   int2fp_stream_if.slave   s00_axis,
   int2fp_stream_if.master  m00_axis,
   output logic             frame_err
);
   localparam int CW = SIZE > 1 ? $clog2(SIZE) : 1;
   logic en, out_hs, at_end, zero_w;
   logic v1, v2, v3, sg1, sg2, l1, l2, l3, z2, up;
   logic [DATA_WIDTH-1:0] mag1, norm2;
   logic [5:0] lz;
   logic [EXP_W-1:0] exp2, exp3;
   logic [MANT_W:0] mant_r;
   fp32_t pack3, d3;
   logic [CW-1:0] cnt;
   assign en = !(v3 && !m00_axis.tready);
   assign s00_axis.tready = en;
   assign out_hs = v3 && m00_axis.tready;
   assign at_end = cnt == CW'(SIZE - 1);
   assign m00_axis.tvalid = v3;
   assign m00_axis.tdata = d3;
   assign m00_axis.tlast = v3 && at_end;
   assign m00_axis.tstrb = '1;
   lzc32 u_lzc (.din(mag1), .cnt(lz), .zero(zero_w));
   // Normalised word: bit 31 is the hidden one, 30:8 mantissa, 7 guard, 6 round, 5:0 sticky.
   always_comb begin
      up = norm2[7] & (norm2[6] | (|norm2[5:0]) | norm2[8]);
      mant_r = {1'b0, norm2[30:8]} + (MANT_W+1)'(up);
      exp3 = exp2 + EXP_W'(mant_r[MANT_W]);
      pack3 = z2 ? fp32_t'(FP_ZERO) : fp32_t'{sg2, exp3, mant_r[MANT_W-1:0]};
   end
   always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
      if (!s00_axi_aresetn) begin
         {v1, v2, v3, sg1, sg2, l1, l2, l3, z2} <= '0;
         mag1 <= '0;
         norm2 <= '0;
         exp2 <= '0;
         d3 <= fp32_t'(FP_ZERO);
         cnt <= '0;
         frame_err <= 1'b0;
      end else begin
         if (en) begin
            v1 <= s00_axis.tvalid;
            sg1 <= s00_axis.tdata[DATA_WIDTH-1];
            mag1 <= s00_axis.tdata[DATA_WIDTH-1] ? -s00_axis.tdata : s00_axis.tdata;
            l1 <= s00_axis.tlast;
            v2 <= v1;
            sg2 <= sg1;
            norm2 <= mag1 << lz;
            exp2 <= EXP_W'(EXP_BIAS + 31 - int'(lz));
            z2 <= zero_w;
            l2 <= l1;
            v3 <= v2;
            d3 <= pack3;
            l3 <= l2;
         end
         if (out_hs) begin
            cnt <= at_end ? '0 : cnt + CW'(1);
            if (l3 != at_end) frame_err <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_int2fp_stream.sv
// tb_int2fp_stream: directed vectors checked against an arithmetic int->fp model and scoreboard.
module tb_int2fp_stream;
   localparam int SIZE = 10;
   typedef struct { logic [31:0] d; logic l; int c; } exp_t;
   typedef struct { logic [31:0] d; logic l; int c; int lat; } log_t;
   logic clk = 1'b0;
   logic rst_n;
   logic frame_err;
   int nchk = 0, nerr = 0, cyc = 0;
   exp_t q[$];
   log_t out_log[$];
   int m_cnt = 0, last_stall = -100;
   logic m_err = 1'b0, p_stall = 1'b0, p_l;
   logic [31:0] p_d;
   exp_t e;
   int base;
   logic [31:0] vec1 [10] = '{32'd1, 32'hFFFF_FFFF, 32'd10, 32'd0, 32'd16777217,
                              32'd16777219, 32'h7FFF_FFFF, 32'h8000_0000, 32'd5, 32'hFFFF_FFF9};
   logic [31:0] exp1 [8] = '{32'h3F80_0000, 32'hBF80_0000, 32'h4120_0000, 32'h0000_0000,
                             32'h4B80_0000, 32'h4B80_0002, 32'h4F00_0000, 32'hCF00_0000};
   int2fp_stream_if #(.DATA_WIDTH(32)) s_if ();
   int2fp_stream_if #(.DATA_WIDTH(32)) m_if ();
   int2fp_stream #(.SIZE(SIZE), .DATA_WIDTH(32)) dut (
      .s00_axi_aclk(clk), .s00_axi_aresetn(rst_n),
      .s00_axis(s_if), .m00_axis(m_if), .frame_err(frame_err)
   );
   initial forever #5 clk = ~clk;
   initial forever begin
      @(posedge clk);
      cyc++;
   end
   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
      nchk++;
      if (a !== x) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", n, a, x);
      end
   endtask
   // Round-to-nearest-even via integer quotient/remainder of the magnitude.
   function automatic logic [31:0] conv(input logic [31:0] x);
      longint m, qq, rem, half;
      int ex, sh;
      logic s;
      s = x[31];
      m = s ? (longint'(1) << 32) - longint'(x) : longint'(x);
      if (m == 0) return 32'h0;
      ex = 0;
      while ((m >> (ex + 1)) != 0) ex++;
      if (ex > 23) begin
         sh = ex - 23;
         qq = m >> sh;
         rem = m - (qq << sh);
         half = longint'(1) << (sh - 1);
         if (rem > half || (rem == half && qq[0])) qq++;
         if (qq == (longint'(1) << 24)) begin
            qq = qq >> 1;
            ex++;
         end
      end else qq = m << (23 - ex);
      return {s, 8'(ex + 127), qq[22:0]};
   endfunction
   initial forever begin
      @(negedge clk);
      if (!rst_n) begin
         q.delete();
         m_cnt = 0;
         m_err = 1'b0;
         p_stall = 1'b0;
         chk("rst_tvalid", {31'b0, m_if.tvalid}, 0);
         chk("rst_s_tready", {31'b0, s_if.tready}, 1);
      end else begin
         chk("frame_err", {31'b0, frame_err}, {31'b0, m_err});
         chk("s_tready", {31'b0, s_if.tready}, {31'b0, !(m_if.tvalid && !m_if.tready)});
         if (p_stall) begin
            chk("held_tvalid", {31'b0, m_if.tvalid}, 1);
            chk("held_tdata", m_if.tdata, p_d);
            chk("held_tlast", {31'b0, m_if.tlast}, {31'b0, p_l});
         end
         if (m_if.tvalid) begin
            if (q.size() == 0) begin
               nchk++;
               nerr++;
               $display("FAIL unexpected_output: got %h expected none", m_if.tdata);
            end else begin
               e = q[0];
               chk("tdata", m_if.tdata, e.d);
               chk("tlast", {31'b0, m_if.tlast}, {31'b0, m_cnt == SIZE - 1});
               if (m_if.tready) begin
                  if (e.c > last_stall) chk("latency", cyc - e.c, 3);
                  out_log.push_back('{m_if.tdata, m_if.tlast, cyc, cyc - e.c});
                  if (e.l != (m_cnt == SIZE - 1)) m_err = 1'b1;
                  m_cnt = (m_cnt == SIZE - 1) ? 0 : m_cnt + 1;
                  void'(q.pop_front());
               end
            end
         end
         if (s_if.tvalid && s_if.tready) q.push_back('{conv(s_if.tdata), s_if.tlast, cyc});
         p_stall = m_if.tvalid && !m_if.tready;
         if (p_stall) last_stall = cyc;
         p_d = m_if.tdata;
         p_l = m_if.tlast;
      end
   end
   task automatic send(input logic [31:0] d, input logic l);
      int n = 0;
      s_if.tvalid = 1'b1;
      s_if.tdata = d;
      s_if.tlast = l;
      @(negedge clk);
      while (!s_if.tready && n < 100) begin
         n++;
         @(negedge clk);
      end
      if (n >= 100) begin
         nchk++;
         nerr++;
         $display("FAIL send_timeout: got tready=0 expected tready=1");
      end
      @(posedge clk);
      #1;
   endtask
   task automatic idle();
      s_if.tvalid = 1'b0;
      s_if.tlast = 1'b0;
   endtask
   task automatic drain();
      int n = 0;
      while (q.size() != 0 && n < 100) begin
         n++;
         @(negedge clk);
      end
      repeat (2) @(posedge clk);
      #1;
      chk("drain_empty", 32'(q.size()), 0);
   endtask
   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask
   initial begin
      rst_n = 1'b0;
      s_if.tvalid = 1'b0;
      s_if.tdata = '0;
      s_if.tlast = 1'b0;
      s_if.tstrb = '1;
      m_if.tready = 1'b1;
      chk("model_3", conv(32'd3), 32'h4040_0000);
      chk("model_tie", conv(32'd16777217), 32'h4B80_0000);
      chk("model_carry", conv(32'h7FFF_FFFF), 32'h4F00_0000);
      repeat (3) @(posedge clk);
      #1;
      chk("reset_tvalid", {31'b0, m_if.tvalid}, 0);
      chk("reset_tlast", {31'b0, m_if.tlast}, 0);
      chk("reset_tdata", m_if.tdata, 0);
      chk("reset_frame_err", {31'b0, frame_err}, 0);
      chk("reset_s_tready", {31'b0, s_if.tready}, 1);
      chk("tstrb", {28'b0, m_if.tstrb}, 32'hF);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      base = out_log.size();
      for (int i = 0; i < 10; i++) send(vec1[i], i == 9);
      idle();
      drain();
      chk("p1_count", 32'(out_log.size() - base), 10);
      if (out_log.size() - base >= 10)
         for (int i = 0; i < 8; i++) begin
            chk($sformatf("p1_data%0d", i), out_log[base+i].d, exp1[i]);
            chk($sformatf("p1_lat%0d", i), out_log[base+i].lat, 3);
         end
      base = out_log.size();
      for (int i = 0; i < 20; i++) send(32'(i * 123457 - 1000000), i == 9 || i == 19);
      idle();
      drain();
      chk("p2_count", 32'(out_log.size() - base), 20);
      if (out_log.size() - base >= 20)
         for (int i = 0; i < 20; i++) begin
            chk($sformatf("p2_tlast%0d", i), {31'b0, out_log[base+i].l}, {31'b0, i == 9 || i == 19});
            if (i > 0) chk($sformatf("p2_gap%0d", i), out_log[base+i].c - out_log[base+i-1].c, 1);
         end
      chk("p2_frame_err", {31'b0, frame_err}, 0);
      base = out_log.size();
      fork
         for (int i = 0; i < 12; i++) send(32'(i * 7919 - 40000), i == 9);
         begin
            repeat (6) @(posedge clk);
            #1;
            m_if.tready = 1'b0;
            repeat (5) begin
               @(negedge clk);
               chk("stall_s_tready", {31'b0, s_if.tready}, 0);
            end
            @(posedge clk);
            #1;
            m_if.tready = 1'b1;
         end
      join
      idle();
      drain();
      chk("p3_count", 32'(out_log.size() - base), 12);
      do_reset();
      base = out_log.size();
      for (int i = 0; i < 10; i++) send(32'(i * 3 - 11), i == 6);
      idle();
      drain();
      chk("p4_frame_err", {31'b0, frame_err}, 1);
      repeat (3) @(posedge clk);
      #1;
      chk("p4_frame_err_held", {31'b0, frame_err}, 1);
      do_reset();
      for (int i = 0; i < 3; i++) send(32'(100 + i), 1'b0);
      idle();
      chk("inflight_tvalid", {31'b0, m_if.tvalid}, 1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("async_tvalid", {31'b0, m_if.tvalid}, 0);
      chk("async_tdata", m_if.tdata, 0);
      chk("async_s_tready", {31'b0, s_if.tready}, 1);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      base = out_log.size();
      for (int i = 0; i < 10; i++) send(32'(-5000 * i), i == 9);
      idle();
      drain();
      chk("p5_count", 32'(out_log.size() - base), 10);
      if (out_log.size() - base >= 10)
         for (int i = 0; i < 10; i++)
            chk($sformatf("p5_tlast%0d", i), {31'b0, out_log[base+i].l}, {31'b0, i == 9});
      chk("p5_frame_err", {31'b0, frame_err}, 0);
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end
endmodule
